tlb_maint_ctrl: RTL and testbench
=================================

# tlb_maint_ctrl

Sequencer for TLB maintenance operations (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) in the MMU. It accepts one maintenance request at a time from the pipeline and owns the shared search port 1, the read port and the write port of the TLB array for the duration of that request. INVTLB runs as a multi-cycle walk over all entries. Register-to-register timing is unchanged when TLBNUM grows.

## Interface
- TLBNUM, 16, number of TLB entries, power of two, 8..64; IDXW = $clog2(TLBNUM)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  maintenance request valid
- req_ready  out  1  controller can accept a request
- req_op  in  3  operation code: SRCH=0, RD=1, WR=2, FILL=3, INV=4
- req_inv_op  in  5  INVTLB op field
- req_asid  in  10  ASID: rj[9:0] for INV, CSR.ASID for SRCH
- req_vppn  in  19  VPPN: rk[31:13] for INV, CSR.TLBEHI for SRCH
- req_index  in  IDXW  CSR.TLBIDX.INDEX, used by RD and WR
- s1_sel  out  1  0 = data path drives search port 1; 1 = controller drives it
- s1_vppn, s1_asid  out  19, 10  search key while s1_sel=1
- s1_found, s1_index  in  1, IDXW  search result
- r_index  out  IDXW  read-port index
- r_e, r_g, r_ps, r_asid, r_vppn  in  1, 1, 6, 10, 19  read-port entry fields
- we  out  1  write strobe to TLB
- w_index  out  IDXW  write index
- w_sel_clear  out  1  1 = write e=0 with all other fields 0; 0 = write CSR-sourced fields
- resp_valid  out  1  one-cycle completion pulse
- resp_op  out  3  op being completed
- resp_found, resp_index  out  1, IDXW  SRCH result
- resp_err  out  1  INV with an undefined op (op > 6)

## Operation
- States: IDLE, SRCH, READ, WRITE, INV, RESP.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on req_valid && req_ready. All req_* fields are registered at acceptance.
- Transitions from IDLE on acceptance:
  - SRCH→SRCH, RD→READ, WR/FILL→WRITE.
  - INV with op 0..6→INV.
  - INV with op > 6→RESP with resp_err=1.
  - Undefined req_op→RESP with resp_err=1.
- SRCH (1 cycle): s1_sel=1; s1 is driven by the registered key; s1_found and s1_index are registered. Next state RESP.
- READ (1 cycle): r_index = registered index. Next state RESP. r_index is held through RESP so the CSR file samples the read port while resp_valid=1.
- WRITE (1 cycle): we=1, w_sel_clear=0.
  - w_index = registered req_index for WR.
  - w_index = fill index sampled at acceptance for FILL.
  - Next state RESP.
- INV: walk counter i runs 0..TLBNUM-1, one entry per cycle.
  - r_index=i each cycle.
  - If r_e && match(op), then we=1, w_index=i, w_sel_clear=1.
  - After i=TLBNUM-1, next state RESP.
- INV match rules:
  - vmatch: if r_ps==12, r_vppn==vppn; otherwise r_vppn[18:9]==vppn[18:9].
  - op 0,1: all entries.
  - op 2: g=1.
  - op 3: g=0.
  - op 4: g=0 && asid match.
  - op 5: g=0 && asid match && vmatch.
  - op 6: (g=1 || asid match) && vmatch.
- RESP (1 cycle): resp_valid=1; then IDLE.
- Fill index generator advances every cycle, independent of state.
- Outside the states above: we=0, s1_sel=0, r_index=0, w_index=0, w_sel_clear=0.

## Timing
- Latency from acceptance at cycle T:
  - SRCH, RD, WR, FILL, err: resp_valid at T+2 (err at T+1).
  - INV: resp_valid at T+TLBNUM+1.
  - req_ready returns the cycle after resp_valid.
- Data-path search stall is exactly one cycle for SRCH and zero cycles otherwise.
- Read and write in the same INV cycle target the same entry. The TLB array read is combinational, so each entry is evaluated before it is cleared.
- Reset values:
  - State IDLE; req_ready=1.
  - All other outputs 0; walk counter 0.
  - Fill counter 0 (or 1, see Configuration).
- Reset mid-operation: the next cycle is IDLE with we=0. No partial response is issued; entries already cleared stay cleared.
- req_valid held high in RESP is not accepted until IDLE.

## Configuration
- TLB_FILL_LFSR_EN defined: the fill index is a maximal-length IDXW-bit Fibonacci LFSR.
  - Reset seed 1.
  - Taps come from the package table.
  - Index 0 is never produced.
- Macro undefined: free-running IDXW-bit up-counter, reset 0, wraps TLBNUM-1→0.

## Structure
- Package mmu_pkg:
  - req_op encodings.
  - INVTLB op constants.
  - State enum.
  - LFSR tap table for IDXW 3..6.
- Sub-module tlb_inv_match: combinational op/g/asid/vppn/ps match for one entry, instantiated once and fed by the read port.

## Test plan
- SRCH hit: entry 5 holds vppn=0x12345, asid=0x01; request SRCH with the same key → s1_sel=1 at T+1; resp_found=1, resp_index=5 at T+2.
- WR then RD: req_index=3, WR → we=1, w_index=3 at T+1. Then RD index 3 → r_index=3 held during resp_valid.
- INVTLB op 4, asid=0x07, TLBNUM=16, entries 2 and 9 with g=0/asid=7, entry 4 with g=1/asid=7 → we only at walk i=2 and i=9; resp_valid at T+17; entry 4 is retained.
- INVTLB op 6, 2 MiB entry (ps=21), vppn bits [18:9] matching and low bits differing → entry cleared. Same case with ps=12 → entry retained.
- INVTLB op 7 → resp_err=1 at T+1, no we asserted; back-to-back FILL requests → w_index values follow the configured counter/LFSR sequence.
- Reset asserted at walk i=6 of INV op 0 → entries 0..5 invalid, entries 6..15 intact; req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared MMU definitions: maintenance op codes, INVTLB op constants,
// controller state encoding and fill-LFSR tap table.
package mmu_pkg;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [4:0] INV_ALL0        = 5'd0;
  localparam logic [4:0] INV_ALL1        = 5'd1;
  localparam logic [4:0] INV_G1          = 5'd2;
  localparam logic [4:0] INV_G0          = 5'd3;
  localparam logic [4:0] INV_G0_ASID     = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_GASID_VA    = 5'd6;
  localparam logic [4:0] INV_MAX         = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_READ,
    ST_WRITE,
    ST_INV,
    ST_RESP
  } state_t;

  // Fibonacci feedback masks (bit k set = tap on stage k) for maximal-length sequences
  function automatic logic [5:0] lfsr_taps(input int w);
    case (w)
      3:       return 6'b000110;
      4:       return 6'b001100;
      5:       return 6'b010100;
      6:       return 6'b110000;
      default: return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB match decision for a single TLB entry.
module tlb_inv_match
  import mmu_pkg::*;
(
  input  logic [4:0]  op,
  input  logic        ent_e,
  input  logic        ent_g,
  input  logic [5:0]  ent_ps,
  input  logic [9:0]  ent_asid,
  input  logic [18:0] ent_vppn,
  input  logic [9:0]  key_asid,
  input  logic [18:0] key_vppn,
  output logic        hit
);

  logic vmatch;
  logic amatch;
  logic rule;

  // 4 KiB pages compare the full VPPN; larger pages only the upper ten bits
  assign vmatch = (ent_ps == 6'd12) ? (ent_vppn == key_vppn)
                                    : (ent_vppn[18:9] == key_vppn[18:9]);
  assign amatch = (ent_asid == key_asid);

  always_comb begin
    rule = 1'b0;
    case (op)
      INV_ALL0, INV_ALL1: rule = 1'b1;
      INV_G1:             rule = ent_g;
      INV_G0:             rule = ~ent_g;
      INV_G0_ASID:        rule = ~ent_g & amatch;
      INV_G0_ASID_VA:     rule = ~ent_g & amatch & vmatch;
      INV_GASID_VA:       rule = (ent_g | amatch) & vmatch;
      default:            rule = 1'b0;
    endcase
  end

  assign hit = ent_e & rule;

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer (SRCH/RD/WR/FILL/INVTLB walk).
// Build option: TLB_FILL_LFSR_EN selects an LFSR fill index instead of an up-counter.
module tlb_maint_ctrl
  import mmu_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_asid,
  input  logic [18:0]     req_vppn,
  input  logic [IDXW-1:0] req_index,
  output logic            s1_sel,
  output logic [18:0]     s1_vppn,
  output logic [9:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic            r_g,
  input  logic [5:0]      r_ps,
  input  logic [9:0]      r_asid,
  input  logic [18:0]     r_vppn,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic            w_sel_clear,
  output logic            resp_valid,
  output logic [2:0]      resp_op,
  output logic            resp_found,
  output logic [IDXW-1:0] resp_index,
  output logic            resp_err
);

  state_t          state, state_next;
  logic [2:0]      op_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      asid_q;
  logic [18:0]     vppn_q;
  logic [IDXW-1:0] index_q;
  logic [IDXW-1:0] fill_q;
  logic            err_q;
  logic            found_q;
  logic [IDXW-1:0] found_idx_q;
  logic [IDXW-1:0] walk;
  logic [IDXW-1:0] fill_ctr;
  logic            accept;
  logic            inv_hit;

  assign accept = req_valid && (state == ST_IDLE);

  tlb_inv_match u_match (
    .op       (inv_op_q),
    .ent_e    (r_e),
    .ent_g    (r_g),
    .ent_ps   (r_ps),
    .ent_asid (r_asid),
    .ent_vppn (r_vppn),
    .key_asid (asid_q),
    .key_vppn (vppn_q),
    .hit      (inv_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_SRCH:         state_next = ST_SRCH;
            OP_RD:           state_next = ST_READ;
            OP_WR, OP_FILL:  state_next = ST_WRITE;
            OP_INV:          state_next = (req_inv_op <= INV_MAX) ? ST_INV : ST_RESP;
            default:         state_next = ST_RESP;
          endcase
        end
      end
      ST_SRCH, ST_READ, ST_WRITE: state_next = ST_RESP;
      ST_INV:  if (walk == IDXW'(TLBNUM - 1)) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      inv_op_q    <= '0;
      asid_q      <= '0;
      vppn_q      <= '0;
      index_q     <= '0;
      fill_q      <= '0;
      err_q       <= 1'b0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
      walk        <= '0;
    end else begin
      if (accept) begin
        op_q        <= req_op;
        inv_op_q    <= req_inv_op;
        asid_q      <= req_asid;
        vppn_q      <= req_vppn;
        index_q     <= req_index;
        fill_q      <= fill_ctr;
        err_q       <= (req_op == OP_INV) ? (req_inv_op > INV_MAX) : (req_op > OP_INV);
        found_q     <= 1'b0;
        found_idx_q <= '0;
      end
      if (state == ST_SRCH) begin
        found_q     <= s1_found;
        found_idx_q <= s1_index;
      end
      // The walk counter wraps to zero on its own after the last entry
      walk <= (state == ST_INV) ? walk + 1'b1 : '0;
    end
  end

`ifdef TLB_FILL_LFSR_EN
  localparam logic [5:0]      TAPS_ALL = lfsr_taps(IDXW);
  localparam logic [IDXW-1:0] TAPS     = TAPS_ALL[IDXW-1:0];

  always_ff @(posedge clk) begin
    if (reset) fill_ctr <= IDXW'(1);
    else       fill_ctr <= {fill_ctr[IDXW-2:0], ^(fill_ctr & TAPS)};
  end
`else
  always_ff @(posedge clk) begin
    if (reset) fill_ctr <= '0;
    else       fill_ctr <= fill_ctr + 1'b1;
  end
`endif

  // Write strobes are suppressed while reset is held so an interrupted walk
  // leaves the entry under the cursor untouched.
  always_comb begin
    req_ready   = (state == ST_IDLE);
    s1_sel      = 1'b0;
    s1_vppn     = '0;
    s1_asid     = '0;
    r_index     = '0;
    we          = 1'b0;
    w_index     = '0;
    w_sel_clear = 1'b0;
    resp_valid  = 1'b0;
    resp_op     = '0;
    resp_found  = 1'b0;
    resp_index  = '0;
    resp_err    = 1'b0;
    case (state)
      ST_SRCH: begin
        s1_sel  = 1'b1;
        s1_vppn = vppn_q;
        s1_asid = asid_q;
      end
      ST_READ: r_index = index_q;
      ST_WRITE: begin
        if (!reset) begin
          we      = 1'b1;
          w_index = (op_q == OP_FILL) ? fill_q : index_q;
        end
      end
      ST_INV: begin
        r_index = walk;
        if (inv_hit && !reset) begin
          we          = 1'b1;
          w_index     = walk;
          w_sel_clear = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_op    = op_q;
        resp_found = found_q;
        resp_index = found_idx_q;
        resp_err   = err_q;
        if (op_q == OP_RD) r_index = index_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Self-checking bench for tlb_maint_ctrl: emulated TLB array, schedule-based
// reference model compared every cycle, plus directed literal checks.
module tb_tlb_maint_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam int SCHED  = 1024;

  typedef struct packed {
    logic        e;
    logic        g;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic [18:0] vppn;
  } tlbe_t;

  typedef struct packed {
    logic            ready;
    logic            s1_sel;
    logic [18:0]     s1_vppn;
    logic [9:0]      s1_asid;
    logic [IDXW-1:0] r_index;
    logic            we;
    logic [IDXW-1:0] w_index;
    logic            w_clr;
    logic            resp_valid;
    logic [2:0]      resp_op;
    logic            resp_found;
    logic [IDXW-1:0] resp_index;
    logic            resp_err;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_ready;
  logic [2:0]      req_op;
  logic [4:0]      req_inv_op;
  logic [9:0]      req_asid;
  logic [18:0]     req_vppn;
  logic [IDXW-1:0] req_index;
  logic            s1_sel;
  logic [18:0]     s1_vppn;
  logic [9:0]      s1_asid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [IDXW-1:0] r_index;
  logic            r_e, r_g;
  logic [5:0]      r_ps;
  logic [9:0]      r_asid;
  logic [18:0]     r_vppn;
  logic            we;
  logic [IDXW-1:0] w_index;
  logic            w_sel_clear;
  logic            resp_valid;
  logic [2:0]      resp_op;
  logic            resp_found;
  logic [IDXW-1:0] resp_index;
  logic            resp_err;

  tlbe_t tlb [TLBNUM];
  tlbe_t csr_w;
  exp_t  sched [SCHED];
  int    cyc = 0;
  int    since = 0;
  bit    model_on = 1'b0;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_asid(req_asid), .req_vppn(req_vppn),
    .req_index(req_index),
    .s1_sel(s1_sel), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index),
    .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_ps(r_ps), .r_asid(r_asid), .r_vppn(r_vppn),
    .we(we), .w_index(w_index), .w_sel_clear(w_sel_clear),
    .resp_valid(resp_valid), .resp_op(resp_op), .resp_found(resp_found),
    .resp_index(resp_index), .resp_err(resp_err)
  );

  function automatic logic vmatch(tlbe_t t, logic [18:0] vppn);
    return (t.ps == 6'd12) ? (t.vppn == vppn) : (t.vppn[18:9] == vppn[18:9]);
  endfunction

  function automatic logic [IDXW:0] search(logic [18:0] vppn, logic [9:0] asid);
    for (int i = 0; i < TLBNUM; i++)
      if (tlb[i].e && (tlb[i].g || tlb[i].asid == asid) && vmatch(tlb[i], vppn))
        return {1'b1, IDXW'(i)};
    return '0;
  endfunction

  function automatic logic inv_hits(tlbe_t t, int op, logic [9:0] asid, logic [18:0] vppn);
    logic am;
    am = (t.asid == asid);
    if (!t.e) return 1'b0;
    case (op)
      0, 1:    return 1'b1;
      2:       return t.g;
      3:       return !t.g;
      4:       return !t.g && am;
      5:       return !t.g && am && vmatch(t, vppn);
      6:       return (t.g || am) && vmatch(t, vppn);
      default: return 1'b0;
    endcase
  endfunction

  // Fill index n cycles after reset, for either build
  function automatic logic [IDXW-1:0] fill_at(int n);
`ifdef TLB_FILL_LFSR_EN
    case (n % 15)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h4;  3: return 4'h9;
      4: return 4'h3;  5: return 4'h6;  6: return 4'hD;  7: return 4'hA;
      8: return 4'h5;  9: return 4'hB; 10: return 4'h7; 11: return 4'hF;
      12: return 4'hE; 13: return 4'hC; default: return 4'h8;
    endcase
`else
    return IDXW'(n % TLBNUM);
`endif
  endfunction

  function automatic logic [IDXW-1:0] fill_step(logic [IDXW-1:0] a, int n);
`ifdef TLB_FILL_LFSR_EN
    for (int p = 0; p < 15; p++)
      if (fill_at(p) == a) return fill_at(p + n);
    return '0;
`else
    return a + IDXW'(n);
`endif
  endfunction

  function automatic exp_t idle_exp();
    exp_t x;
    x = '0;
    x.ready = 1'b1;
    return x;
  endfunction

  assign r_e    = tlb[r_index].e;
  assign r_g    = tlb[r_index].g;
  assign r_ps   = tlb[r_index].ps;
  assign r_asid = tlb[r_index].asid;
  assign r_vppn = tlb[r_index].vppn;

  always_comb begin
    {s1_found, s1_index} = search(s1_vppn, s1_asid);
  end

  always @(posedge clk) begin
    if (we) tlb[w_index] = w_sel_clear ? tlbe_t'('0) : csr_w;
  end

  task automatic plan(input int t);
    int         n;
    logic       is_err;
    logic [IDXW:0] sr;
    is_err = (req_op > 3'd4) || (req_op == 3'd4 && req_inv_op > 5'd6);
    n = is_err ? 1 : (req_op == 3'd4) ? TLBNUM + 1 : 2;
    for (int k = 1; k <= n; k++) sched[t+k].ready = 1'b0;
    sched[t+n].resp_valid = 1'b1;
    sched[t+n].resp_op    = req_op;
    sched[t+n].resp_err   = is_err;
    if (!is_err) begin
      case (req_op)
        3'd0: begin
          sched[t+1].s1_sel  = 1'b1;
          sched[t+1].s1_vppn = req_vppn;
          sched[t+1].s1_asid = req_asid;
          sr = search(req_vppn, req_asid);
          sched[t+2].resp_found = sr[IDXW];
          sched[t+2].resp_index = sr[IDXW-1:0];
        end
        3'd1: begin
          sched[t+1].r_index = req_index;
          sched[t+2].r_index = req_index;
        end
        3'd2: begin
          sched[t+1].we      = 1'b1;
          sched[t+1].w_index = req_index;
        end
        3'd3: begin
          sched[t+1].we      = 1'b1;
          sched[t+1].w_index = fill_at(since);
        end
        default: begin
          for (int i = 0; i < TLBNUM; i++) begin
            sched[t+1+i].r_index = IDXW'(i);
            if (inv_hits(tlb[i], int'(req_inv_op), req_asid, req_vppn)) begin
              sched[t+1+i].we      = 1'b1;
              sched[t+1+i].w_index = IDXW'(i);
              sched[t+1+i].w_clr   = 1'b1;
            end
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int k = cyc + 1; k < SCHED; k++) sched[k] = idle_exp();
      since    = 0;
      model_on = 1'b1;
    end else begin
      if (model_on && req_valid && cyc < SCHED - TLBNUM - 4 && sched[cyc].ready) plan(cyc);
      since++;
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_on && cyc < SCHED) begin
      exp_t x;
      x = sched[cyc];
      if (reset) begin
        x.we = 1'b0; x.w_index = '0; x.w_clr = 1'b0;
      end
      checkOutput("req_ready",   32'(req_ready),   32'(x.ready));
      checkOutput("s1_sel",      32'(s1_sel),      32'(x.s1_sel));
      checkOutput("s1_vppn",     32'(s1_vppn),     32'(x.s1_vppn));
      checkOutput("s1_asid",     32'(s1_asid),     32'(x.s1_asid));
      checkOutput("r_index",     32'(r_index),     32'(x.r_index));
      checkOutput("we",          32'(we),          32'(x.we));
      checkOutput("w_index",     32'(w_index),     32'(x.w_index));
      checkOutput("w_sel_clear", 32'(w_sel_clear), 32'(x.w_clr));
      checkOutput("resp_valid",  32'(resp_valid),  32'(x.resp_valid));
      checkOutput("resp_op",     32'(resp_op),     32'(x.resp_op));
      checkOutput("resp_found",  32'(resp_found),  32'(x.resp_found));
      checkOutput("resp_index",  32'(resp_index),  32'(x.resp_index));
      checkOutput("resp_err",    32'(resp_err),    32'(x.resp_err));
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) checkOutput("wait_ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] inv_op,
                               input logic [9:0] asid, input logic [18:0] vppn,
                               input logic [IDXW-1:0] index);
    waitIdle();
    req_op     = op;
    req_inv_op = inv_op;
    req_asid   = asid;
    req_vppn   = vppn;
    req_index  = index;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic clearTlb();
    for (int i = 0; i < TLBNUM; i++) tlb[i] = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [IDXW-1:0] fa, fb, fc;
    int              nwe;
    logic [IDXW-1:0] hit0, hit1;

    for (int k = 0; k < SCHED; k++) sched[k] = idle_exp();
    clearTlb();
    csr_w = '0;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_inv_op = '0;
    req_asid = '0; req_vppn = '0; req_index = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);

    // SRCH hit on entry 5
    tlb[5] = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h001, vppn:19'h12345};
    tlb[7] = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h001, vppn:19'h12346};
    applyStimulus(3'd0, 5'd0, 10'h001, 19'h12345, '0);
    @(negedge clk);
    checkOutput("srch_s1_sel", 32'(s1_sel), 32'd1);
    @(negedge clk);
    checkOutput("srch_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("srch_found", 32'(resp_found), 32'd1);
    checkOutput("srch_index", 32'(resp_index), 32'd5);

    // WR index 3, then RD it back
    csr_w = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h022, vppn:19'h0ABCD};
    applyStimulus(3'd2, 5'd0, '0, '0, 4'd3);
    @(negedge clk);
    checkOutput("wr_we", 32'(we), 32'd1);
    checkOutput("wr_w_index", 32'(w_index), 32'd3);
    @(negedge clk);
    checkOutput("wr_entry_vppn", 32'(tlb[3].vppn), 32'h0ABCD);
    applyStimulus(3'd1, 5'd0, '0, '0, 4'd3);
    @(negedge clk);
    checkOutput("rd_r_index", 32'(r_index), 32'd3);
    @(negedge clk);
    checkOutput("rd_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("rd_r_index_held", 32'(r_index), 32'd3);
    checkOutput("rd_r_vppn", 32'(r_vppn), 32'h0ABCD);

    // INVTLB op 4, asid 7
    clearTlb();
    tlb[2]  = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h007, vppn:19'h00100};
    tlb[9]  = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h007, vppn:19'h00200};
    tlb[4]  = '{e:1'b1, g:1'b1, ps:6'd12, asid:10'h007, vppn:19'h00300};
    tlb[10] = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h008, vppn:19'h00400};
    applyStimulus(3'd4, 5'd4, 10'h007, '0, '0);
    nwe = 0; hit0 = '0; hit1 = '0;
    for (int k = 1; k <= TLBNUM + 1; k++) begin
      @(negedge clk);
      if (we) begin
        if (nwe == 0) hit0 = w_index;
        if (nwe == 1) hit1 = w_index;
        nwe++;
      end
      if (k == TLBNUM + 1) checkOutput("inv4_resp_at_T17", 32'(resp_valid), 32'd1);
    end
    checkOutput("inv4_we_count", 32'(nwe), 32'd2);
    checkOutput("inv4_first_hit", 32'(hit0), 32'd2);
    checkOutput("inv4_second_hit", 32'(hit1), 32'd9);
    checkOutput("inv4_entry4_kept", 32'(tlb[4].e), 32'd1);
    checkOutput("inv4_entry10_kept", 32'(tlb[10].e), 32'd1);
    checkOutput("inv4_entry9_gone", 32'(tlb[9].e), 32'd0);

    // INVTLB op 6: 2 MiB page matches on upper bits only, 4 KiB page does not
    clearTlb();
    tlb[0] = '{e:1'b1, g:1'b0, ps:6'd21, asid:10'h003, vppn:{10'h15A, 9'h012}};
    tlb[1] = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h003, vppn:{10'h15A, 9'h012}};
    applyStimulus(3'd4, 5'd6, 10'h003, {10'h15A, 9'h1F0}, '0);
    repeat (TLBNUM + 2) @(negedge clk);
    checkOutput("inv6_2m_cleared", 32'(tlb[0].e), 32'd0);
    checkOutput("inv6_4k_kept", 32'(tlb[1].e), 32'd1);

    // Error paths: INVTLB op 7 and undefined req_op
    applyStimulus(3'd4, 5'd7, '0, '0, '0);
    @(negedge clk);
    checkOutput("inv7_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("inv7_err", 32'(resp_err), 32'd1);
    checkOutput("inv7_no_we", 32'(we), 32'd0);
    applyStimulus(3'd5, 5'd0, '0, '0, '0);
    @(negedge clk);
    checkOutput("badop_err", 32'(resp_err), 32'd1);
    checkOutput("badop_resp_op", 32'(resp_op), 32'd5);

    // Back-to-back FILL requests, three cycles apart
    csr_w = '{e:1'b1, g:1'b1, ps:6'd12, asid:10'h000, vppn:19'h7FFFF};
    applyStimulus(3'd3, 5'd0, '0, '0, '0);
    @(negedge clk);
    checkOutput("fill1_we", 32'(we), 32'd1);
    fa = w_index;
    applyStimulus(3'd3, 5'd0, '0, '0, '0);
    @(negedge clk);
    fb = w_index;
    applyStimulus(3'd3, 5'd0, '0, '0, '0);
    @(negedge clk);
    fc = w_index;
    checkOutput("fill2_step", 32'(fb), 32'(fill_step(fa, 3)));
    checkOutput("fill3_step", 32'(fc), 32'(fill_step(fb, 3)));

    // Reset during walk i=6 of INVTLB op 0
    for (int i = 0; i < TLBNUM; i++)
      tlb[i] = '{e:1'b1, g:1'b0, ps:6'd12, asid:10'h011, vppn:19'(i)};
    applyStimulus(3'd4, 5'd0, '0, '0, '0);
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_walk_index", 32'(r_index), 32'd6);
    checkOutput("rst_we_gated", 32'(we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < TLBNUM; i++)
      checkOutput($sformatf("rst_entry%0d_e", i), 32'(tlb[i].e), (i < 6) ? 32'd0 : 32'd1);

    // Normal operation resumes after the interrupted walk
    applyStimulus(3'd0, 5'd0, 10'h011, 19'd12, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_rst_found", 32'(resp_found), 32'd1);
    checkOutput("post_rst_index", 32'(resp_index), 32'd12);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
